cmp_share_scheduler: RTL and testbench
======================================

Name: cmp_share_scheduler

Overview:
- Round-robin scheduler that shares one external 3-input ">5" comparator (inputs x,y,z; output answer) among NUM_REQ requesters.
- Latches the winner's 3-bit operand and drives the comparator bits, with x as MSB and z as LSB.
- Captures the answer and returns a tagged response.
- Keeps a saturating count of "greater than 5" results for system status.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester id; must be >= clog2(NUM_REQ).
- CNT_W, 8, width of hit counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester request, level.
- req_val  input  3*NUM_REQ  operands; requester i uses bits [3i+2:3i], MSB = bit 3i+2.
- gnt  output  NUM_REQ  one-hot grant, registered, one-cycle pulse.
- cmp_x  output  1  comparator MSB.
- cmp_y  output  1  comparator middle bit.
- cmp_z  output  1  comparator LSB.
- cmp_answer  input  1  comparator result, combinational from cmp_x/y/z.
- rsp_valid  output  1  one-cycle response strobe.
- rsp_id  output  ID_W  id of the requester being answered.
- rsp_result  output  1  captured cmp_answer (1 = operand > 5).
- hit_count  output  CNT_W  number of rsp_result=1 responses since reset; saturating.
- busy  output  1  high while state != IDLE.

Behaviour:
- Reset, sampled on the clk edge:
  - state=IDLE; all outputs 0; round-robin pointer ptr=0.
- Reset has priority over all other events:
  - Reset asserted in EVAL aborts the operation.
  - No rsp_valid is produced for the aborted grant.
- FSM states:
  - IDLE: on the edge where any req bit is 1:
    - Pick winner w = first set req bit searching ptr, ptr+1, ..., wrapping modulo NUM_REQ.
    - Latch op_reg = req_val slice w and id_reg = w.
    - Set gnt[w]=1 for the next cycle; ptr <= (w+1) mod NUM_REQ; go to EVAL.
    - If no req bit is set, stay in IDLE.
  - EVAL, exactly one cycle:
    - gnt is high during this cycle.
    - cmp_x/y/z = op_reg[2]/[1]/[0].
    - At the edge: rsp_result <= cmp_answer; rsp_id <= id_reg; rsp_valid <= 1.
    - If cmp_answer=1 and hit_count != all-ones, hit_count increments.
    - Go to IDLE.
- Latency and throughput:
  - Req sampled at edge T -> gnt high in cycle T+1 -> rsp_valid high in cycle T+2.
  - Maximum throughput is one grant per 2 cycles.
  - The IDLE cycle that carries rsp_valid may accept a new request at its ending edge (back-to-back operation).
- Handshake rules:
  - The requester keeps req and req_val stable until it sees gnt.
  - The operand is captured at the grant edge; later changes to req_val are ignored.
  - The requester drops req in the gnt cycle. A req still high after gnt is treated as a new request.
- Comparator drive: cmp_x/y/z = 0 in IDLE.
- Output timing:
  - gnt and rsp_valid are each high for exactly 1 cycle per operation.
  - rsp_id and rsp_result hold their last values when rsp_valid=0.
- Round-robin fairness:
  - ptr advances past the winner only.
  - With all requesters continuously requesting, grants go 0,1,2,3,0,...
  - A single requester is granted every 2 cycles.
- hit_count saturates at 2^CNT_W-1 and never wraps. Only reset clears it.
- busy = (state == EVAL).

Test Plan:
- Reset, then idle 5 cycles:
  - gnt=0, rsp_valid=0, cmp_x/y/z=0, hit_count=0.
  - Assert reset during an EVAL cycle: no rsp_valid follows, and ptr and hit_count read 0.
- Single requester sweep, req[0] with req_val[2:0] = 0..7 sequentially:
  - rsp_result = 0,0,0,0,0,0,1,1, with rsp_id=0 each time.
  - Each rsp_valid arrives 2 cycles after its req edge.
  - hit_count ends at 2.
- All four requesters held high, operands 3,6,5,7:
  - gnt order is 0,1,2,3,0 on alternating cycles.
  - Responses: (id0,0), (id1,1), (id2,0), (id3,1).
- Round-robin wrap:
  - ptr=3 after granting 2; then req=4'b1001 -> grant 3 then 0.
  - Next req=4'b0011 -> grant 0 is skipped in favour of 1 (ptr=1).
- Operand changed after grant:
  - req[1] operand 7 granted; operand switches to 0 during EVAL.
  - rsp_result=1 is still returned.
- Saturation with CNT_W=2:
  - Five responses with operand 6 -> hit_count goes 1,2,3,3,3.

Source files
------------

// File: rtl/cmp_share_scheduler.sv
// Round-robin scheduler sharing one external 3-input ">5" comparator among
// NUM_REQ requesters. One operation is a grant cycle (EVAL) followed by a
// tagged response; a saturating counter tracks how many answers were 1.
module cmp_share_scheduler #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [3*NUM_REQ-1:0] req_val_i,
    output logic [NUM_REQ-1:0]   gnt_o,
    output logic                 cmp_x_o,
    output logic                 cmp_y_o,
    output logic                 cmp_z_o,
    input  logic                 cmp_answer_i,
    output logic                 rsp_valid_o,
    output logic [ID_W-1:0]      rsp_id_o,
    output logic                 rsp_result_o,
    output logic [CNT_W-1:0]     hit_count_o,
    output logic                 busy_o
);

    typedef enum logic {StIdle, StEval} state_e;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [2:0]         op_q, op_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic               rsp_result_q, rsp_result_d;
    logic [CNT_W-1:0]   hit_q, hit_d;

    // Requests rotated so that bit 0 is the requester at ptr.
    logic [NUM_REQ-1:0] req_rot;
    logic               win_found;
    int unsigned        win_idx;
    logic [2:0]         win_op;
    logic [NUM_REQ-1:0] win_onehot;

    // Winner search: first set request starting at ptr, wrapping around.
    always_comb begin
        req_rot    = NUM_REQ'({req_i, req_i} >> ptr_q);
        win_found  = 1'b0;
        win_idx    = 0;
        win_op     = '0;
        win_onehot = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!win_found && req_rot[k]) begin
                win_found = 1'b1;
                win_idx   = (32'(ptr_q) + k) % NUM_REQ;
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_idx == i) begin
                win_op        = req_val_i[3*i +: 3];
                win_onehot[i] = win_found;
            end
        end
    end

    // Next-state logic: grant in IDLE, capture the comparator answer in EVAL.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        op_d         = op_q;
        id_d         = id_q;
        gnt_d        = '0;
        rsp_valid_d  = 1'b0;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        hit_d        = hit_q;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    op_d    = win_op;
                    id_d    = ID_W'(win_idx);
                    gnt_d   = win_onehot;
                    ptr_d   = ID_W'((win_idx + 1) % NUM_REQ);
                    state_d = StEval;
                end
            end
            StEval: begin
                rsp_valid_d  = 1'b1;
                rsp_id_d     = id_q;
                rsp_result_d = cmp_answer_i;
                if (cmp_answer_i && (hit_q != '1)) begin
                    hit_d = hit_q + CNT_W'(1);
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset aborts any in-flight operation.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            op_q         <= '0;
            id_q         <= '0;
            gnt_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= 1'b0;
            hit_q        <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            op_q         <= op_d;
            id_q         <= id_d;
            gnt_q        <= gnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            hit_q        <= hit_d;
        end
    end

    // Comparator inputs are driven only while evaluating.
    always_comb begin
        cmp_x_o = (state_q == StEval) & op_q[2];
        cmp_y_o = (state_q == StEval) & op_q[1];
        cmp_z_o = (state_q == StEval) & op_q[0];
    end

    assign gnt_o        = gnt_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_id_o     = rsp_id_q;
    assign rsp_result_o = rsp_result_q;
    assign hit_count_o  = hit_q;
    assign busy_o       = (state_q == StEval);

endmodule

// File: tb/tb_cmp_share_scheduler.sv
// Bench for cmp_share_scheduler: a second instance with a 2-bit hit counter
// shares the stimulus so saturation is visible quickly.
module tb_cmp_share_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [11:0] req_val;
    logic [3:0]  gnt, gnt2;
    logic        cx, cy, cz, cx2, cy2, cz2;
    logic        ans, ans2;
    logic        rsp_valid, rsp_valid2;
    logic [1:0]  rsp_id, rsp_id2;
    logic        rsp_result, rsp_result2;
    logic [7:0]  hit;
    logic [1:0]  hit2;
    logic        busy, busy2;

    int n_pass = 0;
    int n_total = 0;

    // Reference model state.
    int ptr_m = 0;
    int hit_m = 0;
    int hit2_m = 0;

    always #5 clk = ~clk;

    // External comparator.
    assign ans  = ({cx, cy, cz} > 3'd5);
    assign ans2 = ({cx2, cy2, cz2} > 3'd5);

    cmp_share_scheduler #(.NUM_REQ(4), .ID_W(2), .CNT_W(8)) dut (
        .clk_i(clk), .reset_i(reset), .req_i(req), .req_val_i(req_val), .gnt_o(gnt),
        .cmp_x_o(cx), .cmp_y_o(cy), .cmp_z_o(cz), .cmp_answer_i(ans),
        .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_result_o(rsp_result),
        .hit_count_o(hit), .busy_o(busy)
    );

    cmp_share_scheduler #(.NUM_REQ(4), .ID_W(2), .CNT_W(2)) dut2 (
        .clk_i(clk), .reset_i(reset), .req_i(req), .req_val_i(req_val), .gnt_o(gnt2),
        .cmp_x_o(cx2), .cmp_y_o(cy2), .cmp_z_o(cz2), .cmp_answer_i(ans2),
        .rsp_valid_o(rsp_valid2), .rsp_id_o(rsp_id2), .rsp_result_o(rsp_result2),
        .hit_count_o(hit2), .busy_o(busy2)
    );

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        req = '0;
        req_val = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        ptr_m = 0;
        hit_m = 0;
        hit2_m = 0;
    endtask

    // One operation: present r/v, check grant cycle, then response cycle.
    // hold keeps the request asserted; otherwise req drops and the operand
    // is inverted during EVAL to show it was captured at the grant edge.
    task automatic run_op(input logic [3:0] r, input logic [11:0] v, input bit hold);
        int w;
        logic [2:0] op;
        logic exp_res;
        @(negedge clk);
        req = r;
        req_val = v;
        w = pick(r, ptr_m);
        op = v[3*w +: 3];
        exp_res = (op > 3'd5);
        @(posedge clk);
        #1;
        n_total++;
        if ({gnt, busy, cx, cy, cz} !== {4'(1 << w), 1'b1, op}) begin
            $display("FAIL grant: gnt=%b busy=%b cmp=%b%b%b expected gnt=%b busy=1 cmp=%b",
                     gnt, busy, cx, cy, cz, 4'(1 << w), op);
        end else n_pass++;
        n_total++;
        if (rsp_valid !== 1'b0) begin
            $display("FAIL rsp_early: rsp_valid=%b expected 0", rsp_valid);
        end else n_pass++;
        ptr_m = (w + 1) % 4;
        if (exp_res) begin
            if (hit_m < 255) hit_m++;
            if (hit2_m < 3) hit2_m++;
        end
        if (!hold) begin
            req = '0;
            req_val = ~v;
        end
        @(posedge clk);
        #1;
        n_total++;
        if ({rsp_valid, rsp_id, rsp_result, gnt, busy} !== {1'b1, 2'(w), exp_res, 4'b0, 1'b0})
        begin
            $display("FAIL response: valid=%b id=%0d result=%b gnt=%b busy=%b expected 1 %0d %b 0000 0",
                     rsp_valid, rsp_id, rsp_result, gnt, busy, w, exp_res);
        end else n_pass++;
        n_total++;
        if (hit !== 8'(hit_m) || hit2 !== 2'(hit2_m)) begin
            $display("FAIL hit_count: got %0d/%0d expected %0d/%0d", hit, hit2, hit_m, hit2_m);
        end else n_pass++;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        req = '0;
        @(posedge clk);
        #1;
        n_total++;
        if ({gnt, rsp_valid, busy, cx, cy, cz} !== 9'b0) begin
            $display("FAIL idle: gnt=%b rsp_valid=%b busy=%b cmp=%b%b%b expected all 0",
                     gnt, rsp_valid, busy, cx, cy, cz);
        end else n_pass++;
    endtask

    task automatic test_reset();
        apply_reset();
        n_total++;
        if ({gnt, rsp_valid, rsp_id, rsp_result, hit, busy, cx, cy, cz} !== 20'b0) begin
            $display("FAIL reset_state: gnt=%b rv=%b id=%0d res=%b hit=%0d busy=%b",
                     gnt, rsp_valid, rsp_id, rsp_result, hit, busy);
        end else n_pass++;
        repeat (5) idle_cycle();
    endtask

    task automatic test_reset_in_eval();
        apply_reset();
        run_op(4'b0001, 12'o0007, 1'b0);
        @(negedge clk);
        req = 4'b0100;
        req_val = 12'o0700;
        @(posedge clk);
        #1;
        n_total++;
        if (gnt !== 4'b0100) begin
            $display("FAIL abort_grant: gnt=%b expected 0100", gnt);
        end else n_pass++;
        @(negedge clk);
        req = '0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_total++;
        if ({rsp_valid, hit, busy, gnt} !== 14'b0) begin
            $display("FAIL abort: rv=%b hit=%0d busy=%b gnt=%b expected all 0",
                     rsp_valid, hit, busy, gnt);
        end else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        ptr_m = 0;
        hit_m = 0;
        hit2_m = 0;
        @(posedge clk);
        #1;
        n_total++;
        if (rsp_valid !== 1'b0) begin
            $display("FAIL abort_no_rsp: rsp_valid=%b expected 0", rsp_valid);
        end else n_pass++;
        // Pointer back at 0: all-request grants requester 0.
        run_op(4'b1111, 12'o1234, 1'b0);
    endtask

    task automatic test_single_sweep();
        apply_reset();
        for (int i = 0; i < 8; i++) run_op(4'b0001, 12'(i), 1'b0);
        n_total++;
        if (hit !== 8'd2) begin
            $display("FAIL sweep_hits: hit=%0d expected 2", hit);
        end else n_pass++;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        // Operands 3,6,5,7 for requesters 0..3.
        for (int i = 0; i < 5; i++) run_op(4'b1111, 12'o7563, 1'b1);
        idle_cycle();
    endtask

    task automatic test_rr_wrap();
        apply_reset();
        run_op(4'b0100, 12'o0500, 1'b0);
        run_op(4'b1001, 12'o6002, 1'b0);
        run_op(4'b0001, 12'o0006, 1'b0);
        run_op(4'b0011, 12'o0076, 1'b0);
        idle_cycle();
    endtask

    task automatic test_operand_change();
        apply_reset();
        run_op(4'b0010, 12'o0070, 1'b0);
        n_total++;
        if (rsp_result !== 1'b1) begin
            $display("FAIL operand_change: result=%b expected 1", rsp_result);
        end else n_pass++;
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int i = 0; i < 5; i++) run_op(4'b0100, 12'o0600, 1'b0);
        n_total++;
        if (hit2 !== 2'd3 || hit !== 8'd5) begin
            $display("FAIL saturation: hit2=%0d hit=%0d expected 3 and 5", hit2, hit);
        end else n_pass++;
        for (int i = 0; i < 255; i++) run_op(4'(1 << (i % 4)), 12'o7777, 1'b0);
        n_total++;
        if (hit !== 8'd255) begin
            $display("FAIL saturation8: hit=%0d expected 255", hit);
        end else n_pass++;
    endtask

    task automatic test_random();
        logic [3:0] r;
        apply_reset();
        for (int i = 0; i < 60; i++) begin
            r = 4'($urandom_range(0, 15));
            if (r == 4'b0) idle_cycle();
            else run_op(r, 12'($urandom), 1'($urandom_range(0, 1)));
        end
        idle_cycle();
    endtask

    initial begin
        reset = 1'b1;
        req = '0;
        req_val = '0;
        test_reset();
        test_reset_in_eval();
        test_single_sweep();
        test_back_to_back();
        test_rr_wrap();
        test_operand_change();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
